// File: rtl/whirlpool_mp_round_engine.sv
// Whirlpool W-cipher round engine with optional Miyaguchi-Preneel feed-forward.
// One round per externally supplied subkey; result held until the consumer takes it.
module whirlpool_mp_round_engine #(
   parameter int DATA_W      = 512,
   parameter int ROUNDS      = 10,
   parameter int RND_W       = $clog2(ROUNDS + 1),
   parameter int FEEDFORWARD = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_abort,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_data,
   input  logic [DATA_W-1:0] i_key,
   output logic              o_subkey_req,
   output logic [RND_W-1:0]  o_subkey_idx,
   input  logic              i_subkey_valid,
   input  logic [DATA_W-1:0] i_subkey,
   output logic              o_hash_valid,
   input  logic              i_hash_ready,
   output logic [DATA_W-1:0] o_hash_out,
   output logic              o_busy
);

   generate
      if (DATA_W != 512) begin : g_bad_width
         $error("whirlpool_mp_round_engine: DATA_W must be 512");
      end
      if (ROUNDS < 1) begin : g_bad_rounds
         $error("whirlpool_mp_round_engine: ROUNDS must be >= 1");
      end
   endgenerate

   // S-box mini-boxes E, E^-1 and R, nibble 0 in the top position
   localparam logic [63:0] LP_MB_E    = 64'h1B9CD6F3E874A250;
   localparam logic [63:0] LP_MB_EINV = 64'hF0D7BE5A92C13486;
   localparam logic [63:0] LP_MB_R    = 64'h7CBDE49F638A2510;
   // first row of the MixRows circulant: 01 01 04 01 08 05 02 09
   localparam logic [31:0] LP_COEF    = 32'h11418529;
   localparam logic [RND_W-1:0] LP_LAST = RND_W'(ROUNDS);

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

   function automatic logic [3:0] f_nib(input logic [63:0] tab, input logic [3:0] x);
      logic [63:0] t;
      t = tab >> {(4'd15 - x), 2'b00};
      return t[3:0];
   endfunction

   function automatic logic [7:0] f_sbox(input logic [7:0] u);
      logic [3:0] a, b, r;
      a = f_nib(LP_MB_E, u[7:4]);
      b = f_nib(LP_MB_EINV, u[3:0]);
      r = f_nib(LP_MB_R, a ^ b);
      return {f_nib(LP_MB_E, a ^ r), f_nib(LP_MB_EINV, b ^ r)};
   endfunction

   function automatic logic [7:0] f_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (8'h1D & {8{a[7]}});
   endfunction

   function automatic logic [3:0] f_coef(input int idx);
      logic [31:0] t;
      t = LP_COEF >> (4 * (7 - idx));
      return t[3:0];
   endfunction

   // GF(2^8) product with a coefficient built from 1/2/4/8 terms
   function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [3:0] c);
      logic [7:0] x2, x4, x8;
      x2 = f_xtime(a);
      x4 = f_xtime(x2);
      x8 = f_xtime(x4);
      return (c[0] ? a : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
             (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
   endfunction

   // SubBytes, ShiftColumns (column j rotated down by j), MixRows; byte 0 is the MSB
   function automatic logic [DATA_W-1:0] f_round(input logic [DATA_W-1:0] x);
      logic [7:0]        s [8][8];
      logic [7:0]        p [8][8];
      logic [7:0]        acc;
      logic [DATA_W-1:0] y;
      y = '0;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            s[i][j] = f_sbox(x[DATA_W-1-8*(8*i+j) -: 8]);
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            p[i][j] = s[(i - j) & 7][j];
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            acc = 8'h00;
            for (int k = 0; k < 8; k++)
               acc = acc ^ f_gmul(p[i][k], f_coef((j - k) & 7));
            y[DATA_W-1-8*(8*i+j) -: 8] = acc;
         end
      end
      return y;
   endfunction

   state_t            r_state, w_state_nxt;
   logic [RND_W-1:0]  r_round;
   logic [DATA_W-1:0] r_st, r_ff, r_result;
   logic [DATA_W-1:0] w_blk, w_rnd;
   logic              w_accept, w_sk, w_last;

   assign w_blk      = i_data ^ i_key;
   assign w_rnd      = f_round(r_st) ^ i_subkey;
   assign w_last     = (r_round == LP_LAST);
   assign o_in_ready = !i_abort && ((r_state == S_IDLE) ||
                                    ((r_state == S_DONE) && i_hash_ready));
   assign w_accept   = i_in_valid && o_in_ready;
   assign w_sk       = (r_state == S_ROUND) && i_subkey_valid;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (i_abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ROUND;
            S_ROUND: if (w_sk && w_last) w_state_nxt = S_DONE;
            S_DONE:  if (i_hash_ready) w_state_nxt = w_accept ? S_ROUND : S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_round  <= '0;
         r_st     <= '0;
         r_ff     <= '0;
         r_result <= '0;
      end else if (i_abort) begin
         r_round  <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_st    <= w_blk;
         r_ff    <= (FEEDFORWARD != 0) ? w_blk : '0;
         r_round <= RND_W'(1);
      end else if (w_sk) begin
         r_st <= w_rnd;
         if (w_last) begin
            r_result <= w_rnd ^ r_ff;
            r_round  <= '0;
         end else begin
            r_round <= r_round + RND_W'(1);
         end
      end
   end

   assign o_subkey_req = (r_state == S_ROUND);
   assign o_subkey_idx = (r_state == S_ROUND) ? r_round : '0;
   assign o_hash_valid = (r_state == S_DONE);
   assign o_hash_out   = r_result;
   assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_whirlpool_mp_round_engine.sv
// Bench for whirlpool_mp_round_engine: reference Whirlpool model, ISO empty-string digest,
// stalls, backpressure, back-to-back blocks, abort, reset and a raw 2-round instance.
module tb_whirlpool_mp_round_engine;
   localparam int W  = 512;
   localparam int NR = 10;
   localparam logic [W-1:0] DIGEST_EMPTY =
      512'h19FA61D75522A4669B44E39C1D2E1726C530232130D407F89AFEE0964997F7A73E83BE698B288FEBCF88E3E03C4F0757EA8964E59B63D93708B138CC42A66EB3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, abort_i, in_valid, sk_valid, hash_ready;
   logic [W-1:0] data, key, subkey;
   logic         in_ready, sk_req, hash_valid, busy;
   logic [3:0]   sk_idx;
   logic [W-1:0] hash_out;

   logic         abort2, in_valid2, sk_valid2, hash_ready2;
   logic [W-1:0] data2, key2, subkey2;
   logic         in_ready2, sk_req2, hash_valid2, busy2;
   logic [1:0]   sk_idx2;
   logic [W-1:0] hash_out2;

   whirlpool_mp_round_engine #(.DATA_W(W), .ROUNDS(NR), .RND_W(4), .FEEDFORWARD(1)) dut (
      .i_clk(clk), .i_rst(rst), .i_abort(abort_i), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_data(data), .i_key(key), .o_subkey_req(sk_req), .o_subkey_idx(sk_idx),
      .i_subkey_valid(sk_valid), .i_subkey(subkey), .o_hash_valid(hash_valid),
      .i_hash_ready(hash_ready), .o_hash_out(hash_out), .o_busy(busy));

   whirlpool_mp_round_engine #(.DATA_W(W), .ROUNDS(2), .RND_W(2), .FEEDFORWARD(0)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_abort(abort2), .i_in_valid(in_valid2), .o_in_ready(in_ready2),
      .i_data(data2), .i_key(key2), .o_subkey_req(sk_req2), .o_subkey_idx(sk_idx2),
      .i_subkey_valid(sk_valid2), .i_subkey(subkey2), .o_hash_valid(hash_valid2),
      .i_hash_ready(hash_ready2), .o_hash_out(hash_out2), .o_busy(busy2));

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int mb_e  [16] = '{1, 11, 9, 12, 13, 6, 15, 3, 14, 8, 7, 4, 10, 2, 5, 0};
   int mb_ei [16] = '{15, 0, 13, 7, 11, 14, 5, 10, 9, 2, 12, 1, 3, 4, 8, 6};
   int mb_r  [16] = '{7, 12, 11, 13, 14, 4, 9, 15, 6, 3, 8, 10, 2, 5, 1, 0};
   logic [7:0]   sb [256];
   logic [W-1:0] sk_iso [1:NR];
   logic [W-1:0] sk_tab [1:NR];

   task automatic build_sbox();
      for (int u = 0; u < 256; u++) begin
         int a, b, r;
         a = mb_e[u / 16];
         b = mb_ei[u % 16];
         r = mb_r[a ^ b];
         sb[u] = 8'((mb_e[a ^ r] * 16) + mb_ei[b ^ r]);
      end
   endtask

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1D) : {a[6:0], 1'b0};
      end
      return r;
   endfunction

   function automatic logic [W-1:0] ref_round(input logic [W-1:0] x);
      logic [7:0]   m [8][8];
      logic [7:0]   sh [8][8];
      logic [7:0]   cv [8];
      logic [7:0]   acc;
      logic [W-1:0] y = '0;
      cv = '{8'h01, 8'h01, 8'h04, 8'h01, 8'h08, 8'h05, 8'h02, 8'h09};
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            m[r][c] = sb[x[W-1-8*(8*r+c) -: 8]];
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            sh[r][c] = m[(r - c + 8) % 8][c];
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            acc = 8'h00;
            for (int k = 0; k < 8; k++) acc = acc ^ gf_mul(sh[r][k], cv[(c - k + 8) % 8]);
            y[W-1-8*(8*r+c) -: 8] = acc;
         end
      return y;
   endfunction

   function automatic logic [W-1:0] model_mp(input logic [W-1:0] m, input logic [W-1:0] k);
      logic [W-1:0] st = m ^ k;
      for (int r = 1; r <= NR; r++) st = ref_round(st) ^ sk_tab[r];
      return st ^ m ^ k;
   endfunction

   task automatic build_iso_schedule();
      logic [W-1:0] k = '0;
      logic [W-1:0] rc;
      for (int r = 1; r <= NR; r++) begin
         rc = '0;
         for (int j = 0; j < 8; j++) rc[W-1-8*j -: 8] = sb[8*(r-1)+j];
         k = ref_round(k) ^ rc;
         sk_iso[r] = k;
      end
   endtask

   function automatic logic [W-1:0] rand_blk();
      logic [W-1:0] v = '0;
      for (int i = 0; i < 16; i++) v = {v[W-33:0], $urandom()};
      return v;
   endfunction

   // ---------------- driving helpers ----------------
   int cyc = 0;
   int stall_mode = 0;
   int exp_idx = 1;
   int acc_cyc = 0;

   function automatic bit stalled(input int c, input int mode);
      if (mode == 1) return (c % 2) == 0;
      if (mode == 2) return (c % 3) == 0;
      return 1'b0;
   endfunction

   function automatic int exp_latency(input int acc, input int mode);
      int got = 0;
      int c = acc;
      while (got < NR) begin
         c++;
         if (!stalled(c, mode)) got++;
      end
      return c - acc + 1;
   endfunction

   // subkey server plus index monitor for the 10-round instance
   task automatic tick();
      bit st;
      @(negedge clk);
      cyc++;
      sk_valid = 1'b0;
      subkey   = '0;
      if (sk_req && sk_idx >= 4'd1 && sk_idx <= 4'(NR)) begin
         st       = (stall_mode == 3) ? ($urandom_range(0, 2) == 0) : stalled(cyc, stall_mode);
         subkey   = st ? ~sk_tab[sk_idx] : sk_tab[sk_idx];
         sk_valid = !st;
         check("subkey_idx", W'(sk_idx), W'(exp_idx));
         if (!st) exp_idx = (exp_idx == NR) ? 1 : exp_idx + 1;
      end
   endtask

   task automatic send_block(input logic [W-1:0] m, input logic [W-1:0] k);
      tick();
      in_valid = 1'b1;
      data     = m;
      key      = k;
      #1;
      check("in_ready_idle", W'(in_ready), W'(1));
      acc_cyc = cyc;
      exp_idx = 1;
   endtask

   task automatic wait_done(output int lat);
      int n = 0;
      do begin
         tick();
         in_valid = 1'b0;
         data     = rand_blk();
         #1;
         n++;
      end while (!hash_valid && n < 300);
      check("done_reached", W'(hash_valid), W'(1));
      lat = cyc - acc_cyc;
   endtask

   task automatic take_result();
      tick();
      hash_ready = 1'b1;
      #1;
      check("in_ready_done_hs", W'(in_ready), W'(1));
      tick();
      hash_ready = 1'b0;
      #1;
      check("idle_after_hs", W'(busy), W'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] m0, mr, kr, exp_v, m2, k2, s1, s2;
      logic [W-1:0] mq [3];
      logic [W-1:0] kq [3];
      logic [W-1:0] eq [3];
      int           acc [3];
      int           lat, b, nout;

      rst = 1'b1; abort_i = 1'b0; in_valid = 1'b0; sk_valid = 1'b0; hash_ready = 1'b0;
      data = '0; key = '0; subkey = '0;
      abort2 = 1'b0; in_valid2 = 1'b0; sk_valid2 = 1'b0; hash_ready2 = 1'b0;
      data2 = '0; key2 = '0; subkey2 = '0;
      build_sbox();
      build_iso_schedule();
      m0 = '0;
      m0[W-1 -: 8] = 8'h80;

      // reset state
      tick(); tick();
      #1;
      check("rst_hash_out", hash_out, '0);
      check("rst_hash_valid", W'(hash_valid), W'(0));
      check("rst_subkey_req", W'(sk_req), W'(0));
      check("rst_subkey_idx", W'(sk_idx), W'(0));
      check("rst_busy", W'(busy), W'(0));
      check("rst2_hash_out", hash_out2, '0);
      rst = 1'b0;

      // empty-string digest, no stalls
      for (int r = 1; r <= NR; r++) sk_tab[r] = sk_iso[r];
      stall_mode = 0;
      send_block(m0, '0);
      wait_done(lat);
      check("t1_latency", W'(lat), W'(NR + 1));
      check("t1_digest", hash_out, DIGEST_EMPTY);
      take_result();

      // same block with periodic subkey stalls
      for (int mode = 1; mode <= 2; mode++) begin
         stall_mode = mode;
         send_block(m0, '0);
         wait_done(lat);
         check("t2_latency", W'(lat), W'(exp_latency(acc_cyc, mode)));
         check("t2_digest", hash_out, DIGEST_EMPTY);
         take_result();
      end

      // random block, random stalls, then output backpressure
      for (int r = 1; r <= NR; r++) sk_tab[r] = rand_blk();
      stall_mode = 3;
      mr = rand_blk();
      kr = rand_blk();
      exp_v = model_mp(mr, kr);
      send_block(mr, kr);
      wait_done(lat);
      for (int i = 0; i < 6; i++) begin
         tick();
         in_valid = 1'b1;
         data     = rand_blk();
         key      = rand_blk();
         #1;
         check("t3_hold_out", hash_out, exp_v);
         check("t3_hold_valid", W'(hash_valid), W'(1));
         check("t3_in_ready", W'(in_ready), W'(0));
      end
      tick();
      in_valid = 1'b0;
      take_result();

      // three blocks back to back with valid and ready held
      stall_mode = 0;
      for (int i = 0; i < 3; i++) begin
         mq[i] = rand_blk();
         kq[i] = rand_blk();
         eq[i] = model_mp(mq[i], kq[i]);
      end
      hash_ready = 1'b1;
      exp_idx = 1;
      b = 0;
      nout = 0;
      for (int t = 0; t < 120 && nout < 3; t++) begin
         tick();
         in_valid = (b < 3);
         data     = mq[(b < 3) ? b : 0];
         key      = kq[(b < 3) ? b : 0];
         #1;
         if (hash_valid) begin
            check("t4_digest", hash_out, eq[nout]);
            nout++;
         end
         if (in_valid && in_ready) begin
            acc[b] = cyc;
            b++;
         end
      end
      check("t4_outputs", W'(nout), W'(3));
      check("t4_accepts", W'(b), W'(3));
      check("t4_spacing01", W'(acc[1] - acc[0]), W'(NR + 1));
      check("t4_spacing12", W'(acc[2] - acc[1]), W'(NR + 1));
      tick();
      hash_ready = 1'b0;
      in_valid   = 1'b0;
      #1;
      check("t4_idle", W'(busy), W'(0));

      // abort at round 4, then a clean block
      for (int r = 1; r <= NR; r++) sk_tab[r] = sk_iso[r];
      send_block(m0, '0);
      for (int t = 0; t < 40; t++) begin
         tick();
         in_valid = 1'b0;
         if (sk_idx == 4'd4) break;
      end
      check("t5_at_idx4", W'(sk_idx), W'(4));
      abort_i  = 1'b1;
      in_valid = 1'b1;
      #1;
      check("t5_in_ready_abort", W'(in_ready), W'(0));
      tick();
      abort_i  = 1'b0;
      in_valid = 1'b0;
      #1;
      check("t5_busy", W'(busy), W'(0));
      check("t5_hash_valid", W'(hash_valid), W'(0));
      check("t5_hash_out", hash_out, '0);
      check("t5_subkey_idx", W'(sk_idx), W'(0));
      send_block(m0, '0);
      wait_done(lat);
      check("t5_latency", W'(lat), W'(NR + 1));
      check("t5_digest", hash_out, DIGEST_EMPTY);
      take_result();

      // reset mid-operation at round 7
      for (int r = 1; r <= NR; r++) sk_tab[r] = rand_blk();
      send_block(rand_blk(), rand_blk());
      for (int t = 0; t < 40; t++) begin
         tick();
         in_valid = 1'b0;
         if (sk_idx == 4'd7) break;
      end
      check("t6_at_idx7", W'(sk_idx), W'(7));
      rst = 1'b1;
      tick();
      #1;
      check("t6_rst_hash_out", hash_out, '0);
      check("t6_rst_hash_valid", W'(hash_valid), W'(0));
      check("t6_rst_subkey_req", W'(sk_req), W'(0));
      check("t6_rst_subkey_idx", W'(sk_idx), W'(0));
      check("t6_rst_busy", W'(busy), W'(0));
      rst = 1'b0;

      // raw 2-round cipher instance
      m2 = rand_blk();
      k2 = rand_blk();
      s1 = rand_blk();
      s2 = rand_blk();
      tick();
      in_valid2 = 1'b1;
      data2     = m2;
      key2      = k2;
      #1;
      check("t6_in_ready2", W'(in_ready2), W'(1));
      acc_cyc = cyc;
      for (int t = 0; t < 20; t++) begin
         tick();
         in_valid2 = 1'b0;
         data2     = rand_blk();
         sk_valid2 = sk_req2;
         subkey2   = (sk_idx2 == 2'd1) ? s1 : s2;
         #1;
         if (hash_valid2) break;
      end
      check("t6_raw_valid", W'(hash_valid2), W'(1));
      check("t6_raw_latency", W'(cyc - acc_cyc), W'(3));
      check("t6_raw_out", hash_out2, ref_round(ref_round(m2 ^ k2) ^ s1) ^ s2);
      tick();
      hash_ready2 = 1'b1;
      tick();
      hash_ready2 = 1'b0;
      #1;
      check("t6_raw_idle", W'(busy2), W'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
